bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter_pkg.sv | 28 ++
 rtl/bus_arbiter.sv | 127 ++++++++++++
 tb/tb_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the instruction/data bus arbiter: FSM state
// encoding, owner tags, the latched request record and the stall bus width.
package bus_arbiter_pkg;

   // FSM state encoding (legacy-compatible constants)
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   // Width of the stall pattern bus driven by the pipeline stall controller
   localparam int STALL_W = 6;

   // Which pipeline stage owns the transaction currently on the bus
   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_t;

   // Request fields captured at grant time and replayed onto the bus
   typedef struct packed {
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
   } xfer_t;

   localparam xfer_t XFER_ZERO = '{wen: 4'h0, addr: 32'h0, wdata: 32'h0};

endpackage

// File: rtl/bus_arbiter.sv
// Two-master arbiter sharing one memory bus between the IF-stage fetch port
// and the MEM-stage load/store port. Data has fixed priority. Each
// transaction runs IDLE -> ADDR -> (DATA) -> IDLE, and the owner sees a
// registered one-cycle ok pulse with its read data.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no transaction; grant data first, then inst (not while ok high)
//   ADDR    | bus_req high with latched fields, waiting for bus_addr_ok
//   DATA    | address accepted, bus_req low, waiting for bus_data_ok
module bus_arbiter
   import bus_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   // fetch port
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_ok,
   output logic [31:0] inst_rdata,
   // load/store port
   input  logic        data_req,
   input  logic [3:0]  data_wen,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_ok,
   output logic [31:0] data_rdata,
   // shared memory bus
   output logic        bus_req,
   output logic [3:0]  bus_wen,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   input  logic [31:0] bus_rdata,
   // pipeline stall request
   output logic        stallreq_for_bus
);

   logic [1:0] state;
   logic [1:0] state_nxt;
   owner_t     owner;
   xfer_t      lat;
   logic       ok_busy;
   logic       grant_data;
   logic       grant_inst;
   logic       addr_done;
   logic       done;

   // An ok pulse still high means the owner has not yet dropped its request,
   // so granting now would replay the transaction that just finished.
   assign ok_busy    = inst_ok | data_ok;
   assign grant_data = (state == ST_IDLE) & ~ok_busy & data_req;
   assign grant_inst = (state == ST_IDLE) & ~ok_busy & ~data_req & inst_req;
   assign addr_done  = (state == ST_ADDR) & bus_addr_ok;
   // Completion: normal data phase, or zero-wait when both acks coincide
   assign done       = ((state == ST_ADDR) & bus_addr_ok & bus_data_ok) |
                       ((state == ST_DATA) & bus_data_ok);

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (grant_data | grant_inst) state_nxt = ST_ADDR;
         ST_ADDR: begin
            if (bus_addr_ok & bus_data_ok) state_nxt = ST_IDLE;
            else if (bus_addr_ok)          state_nxt = ST_DATA;
         end
         ST_DATA: if (bus_data_ok) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // Capture owner and request fields at grant; inst fetches are reads
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         owner <= OWN_INST;
         lat   <= XFER_ZERO;
      end else if (grant_data) begin
         owner     <= OWN_DATA;
         lat.wen   <= data_wen;
         lat.addr  <= data_addr;
         lat.wdata <= data_wdata;
      end else if (grant_inst) begin
         owner     <= OWN_INST;
         lat.wen   <= 4'h0;
         lat.addr  <= inst_addr;
         lat.wdata <= 32'h0;
      end
   end

   // Bus request: raised with the grant, dropped once the address is taken
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                        bus_req <= 1'b0;
      else if (grant_data | grant_inst)   bus_req <= 1'b1;
      else if (addr_done)                 bus_req <= 1'b0;
   end

   // Completion: steer read data to the owner and pulse its ok for one cycle
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         inst_ok    <= 1'b0;
         data_ok    <= 1'b0;
         inst_rdata <= 32'h0;
         data_rdata <= 32'h0;
      end else begin
         inst_ok <= done & (owner == OWN_INST);
         data_ok <= done & (owner == OWN_DATA);
         if (done & (owner == OWN_INST)) inst_rdata <= bus_rdata;
         if (done & (owner == OWN_DATA)) data_rdata <= bus_rdata;
      end
   end

   assign bus_wen   = lat.wen;
   assign bus_addr  = lat.addr;
   assign bus_wdata = lat.wdata;

   // Combinational so the pipeline freezes in the same cycle a request appears
   assign stallreq_for_bus = (inst_req & ~inst_ok) | (data_req & ~data_ok);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a per-cycle vector table for the main
// flows, then hand-written back-pressure and reset-mid-transaction sequences.
module tb_bus_arbiter;

   logic        clk;
   logic        resetn;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic [3:0]  data_wen;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_ok;
   logic [31:0] data_rdata;
   logic        bus_req;
   logic [3:0]  bus_wen;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;
   logic        stallreq_for_bus;

   int checks = 0;
   int errors = 0;

   bus_arbiter dut (
      .clk              (clk),
      .resetn           (resetn),
      .inst_req         (inst_req),
      .inst_addr        (inst_addr),
      .inst_ok          (inst_ok),
      .inst_rdata       (inst_rdata),
      .data_req         (data_req),
      .data_wen         (data_wen),
      .data_addr        (data_addr),
      .data_wdata       (data_wdata),
      .data_ok          (data_ok),
      .data_rdata       (data_rdata),
      .bus_req          (bus_req),
      .bus_wen          (bus_wen),
      .bus_addr         (bus_addr),
      .bus_wdata        (bus_wdata),
      .bus_addr_ok      (bus_addr_ok),
      .bus_data_ok      (bus_data_ok),
      .bus_rdata        (bus_rdata),
      .stallreq_for_bus (stallreq_for_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // one cycle: inputs, expected stall before the edge, expected regs after
   typedef struct {
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic [3:0]  dw;
      logic [31:0] da;
      logic [31:0] dd;
      logic        ao;
      logic        dok_in;
      logic [31:0] rd;
      logic        e_st;
      logic        e_br;
      logic [31:0] e_ba;
      logic [3:0]  e_bw;
      logic [31:0] e_bwd;
      logic        e_io;
      logic [31:0] e_ird;
      logic        e_dok;
      logic [31:0] e_drd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic ir, input logic [31:0] ia,
      input logic dr, input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
      input logic ao, input logic dok_in, input logic [31:0] rd,
      input logic e_st,
      input logic e_br, input logic [31:0] e_ba, input logic [3:0] e_bw, input logic [31:0] e_bwd,
      input logic e_io, input logic [31:0] e_ird,
      input logic e_dok, input logic [31:0] e_drd);
      vec_t v;
      v.ir = ir;   v.ia = ia;
      v.dr = dr;   v.dw = dw;   v.da = da;   v.dd = dd;
      v.ao = ao;   v.dok_in = dok_in;   v.rd = rd;
      v.e_st = e_st;
      v.e_br = e_br;   v.e_ba = e_ba;   v.e_bw = e_bw;   v.e_bwd = e_bwd;
      v.e_io = e_io;   v.e_ird = e_ird;
      v.e_dok = e_dok; v.e_drd = e_drd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia,
                        input logic dr, input logic [3:0] dw, input logic [31:0] da,
                        input logic [31:0] dd, input logic ao, input logic dok_in,
                        input logic [31:0] rd);
      inst_req    = ir;  inst_addr  = ia;
      data_req    = dr;  data_wen   = dw;  data_addr = da;  data_wdata = dd;
      bus_addr_ok = ao;  bus_data_ok = dok_in;  bus_rdata = rd;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      string p;
      p = $sformatf("v%0d", idx);
      drive(v.ir, v.ia, v.dr, v.dw, v.da, v.dd, v.ao, v.dok_in, v.rd);
      #1;
      chk({p, ".stall"}, {31'h0, stallreq_for_bus}, {31'h0, v.e_st});
      @(posedge clk);
      #1;
      chk({p, ".bus_req"},    {31'h0, bus_req},  {31'h0, v.e_br});
      chk({p, ".bus_addr"},   bus_addr,          v.e_ba);
      chk({p, ".bus_wen"},    {28'h0, bus_wen},  {28'h0, v.e_bw});
      chk({p, ".bus_wdata"},  bus_wdata,         v.e_bwd);
      chk({p, ".inst_ok"},    {31'h0, inst_ok},  {31'h0, v.e_io});
      chk({p, ".inst_rdata"}, inst_rdata,        v.e_ird);
      chk({p, ".data_ok"},    {31'h0, data_ok},  {31'h0, v.e_dok});
      chk({p, ".data_rdata"}, data_rdata,        v.e_drd);
   endtask

   task automatic chk_all_zero(input string p);
      chk({p, ".bus_req"},    {31'h0, bus_req},  32'h0);
      chk({p, ".bus_addr"},   bus_addr,          32'h0);
      chk({p, ".bus_wen"},    {28'h0, bus_wen},  32'h0);
      chk({p, ".bus_wdata"},  bus_wdata,         32'h0);
      chk({p, ".inst_ok"},    {31'h0, inst_ok},  32'h0);
      chk({p, ".inst_rdata"}, inst_rdata,        32'h0);
      chk({p, ".data_ok"},    {31'h0, data_ok},  32'h0);
      chk({p, ".data_rdata"}, data_rdata,        32'h0);
   endtask

   initial begin
      // ---- vector table (cycle by cycle from reset) ----
      // idle / reset state, then spurious bus_data_ok in IDLE
      vecs.push_back(mk(0,0, 0,0,0,0, 0,0,0,                    0, 0,0,0,0, 0,0, 0,0));
      vecs.push_back(mk(0,0, 0,0,0,0, 0,1,32'h12345678,         0, 0,0,0,0, 0,0, 0,0));
      // inst read, addr_ok in ADDR, data_ok two cycles later
      vecs.push_back(mk(1,32'hBFC00000, 0,0,0,0, 0,0,0,         1, 1,32'hBFC00000,0,0, 0,0, 0,0));
      vecs.push_back(mk(1,32'hBFC00000, 0,0,0,0, 1,0,0,         1, 0,32'hBFC00000,0,0, 0,0, 0,0));
      vecs.push_back(mk(1,32'hBFC00000, 0,0,0,0, 0,0,0,         1, 0,32'hBFC00000,0,0, 0,0, 0,0));
      vecs.push_back(mk(1,32'hBFC00000, 0,0,0,0, 0,1,32'h3C010001, 1, 0,32'hBFC00000,0,0, 1,32'h3C010001, 0,0));
      // ok cycle: request still high, stall drops, no regrant
      vecs.push_back(mk(1,32'hBFC00000, 0,0,0,0, 0,0,0,         0, 0,32'hBFC00000,0,0, 0,32'h3C010001, 0,0));
      vecs.push_back(mk(0,0, 0,0,0,0, 0,0,0,                    0, 0,32'hBFC00000,0,0, 0,32'h3C010001, 0,0));
      // simultaneous data store + inst fetch: data first
      vecs.push_back(mk(1,32'hBFC00004, 1,4'hF,32'h80000010,32'hDEADBEEF, 0,0,0, 1, 1,32'h80000010,4'hF,32'hDEADBEEF, 0,32'h3C010001, 0,0));
      // input address changes while in ADDR: latched value must hold
      vecs.push_back(mk(1,32'hBFC00004, 1,4'hF,32'h11111111,32'hDEADBEEF, 1,0,0, 1, 0,32'h80000010,4'hF,32'hDEADBEEF, 0,32'h3C010001, 0,0));
      vecs.push_back(mk(1,32'hBFC00004, 1,4'hF,32'h80000010,32'hDEADBEEF, 0,1,32'hCAFEF00D, 1, 0,32'h80000010,4'hF,32'hDEADBEEF, 0,32'h3C010001, 1,32'hCAFEF00D));
      vecs.push_back(mk(1,32'hBFC00004, 1,4'hF,32'h80000010,32'hDEADBEEF, 0,0,0, 1, 0,32'h80000010,4'hF,32'hDEADBEEF, 0,32'h3C010001, 0,32'hCAFEF00D));
      // data_req dropped: inst granted with wen=0, wdata=0
      vecs.push_back(mk(1,32'hBFC00004, 0,4'hF,32'h80000010,32'hDEADBEEF, 0,0,0, 1, 1,32'hBFC00004,0,0, 0,32'h3C010001, 0,32'hCAFEF00D));
      // zero-wait completion
      vecs.push_back(mk(1,32'hBFC00004, 0,0,0,0, 1,1,32'h24020005, 1, 0,32'hBFC00004,0,0, 1,32'h24020005, 0,32'hCAFEF00D));
      vecs.push_back(mk(0,0, 0,0,0,0, 0,0,0,                    0, 0,32'hBFC00004,0,0, 0,32'h24020005, 0,32'hCAFEF00D));
      // spurious bus_addr_ok in IDLE
      vecs.push_back(mk(0,0, 0,0,0,0, 1,0,0,                    0, 0,32'hBFC00004,0,0, 0,32'h24020005, 0,32'hCAFEF00D));
      // data read; bus_data_ok without addr_ok in ADDR is ignored
      vecs.push_back(mk(0,0, 1,0,32'h80000020,0, 0,0,0,         1, 1,32'h80000020,0,0, 0,32'h24020005, 0,32'hCAFEF00D));
      vecs.push_back(mk(0,0, 1,0,32'h80000020,0, 0,1,32'h99999999, 1, 1,32'h80000020,0,0, 0,32'h24020005, 0,32'hCAFEF00D));
      vecs.push_back(mk(0,0, 1,0,32'h80000020,0, 1,0,0,         1, 0,32'h80000020,0,0, 0,32'h24020005, 0,32'hCAFEF00D));
      vecs.push_back(mk(0,0, 1,0,32'h80000020,0, 0,1,32'h0000ABCD, 1, 0,32'h80000020,0,0, 0,32'h24020005, 1,32'h0000ABCD));
      vecs.push_back(mk(0,0, 1,0,32'h80000020,0, 0,0,0,         0, 0,32'h80000020,0,0, 0,32'h24020005, 0,32'h0000ABCD));
      vecs.push_back(mk(0,0, 0,0,0,0, 0,0,0,                    0, 0,32'h80000020,0,0, 0,32'h24020005, 0,32'h0000ABCD));

      // ---- reset ----
      resetn = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      resetn = 1'b1;

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // ---- back-pressure: addr_ok withheld for 5 cycles ----
      drive(1, 32'hBFC00010, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("bp.grant.bus_req", {31'h0, bus_req}, 32'h1);
      for (int k = 0; k < 5; k++) begin
         drive(1, 32'h00000000, 0, 0, 0, 0, 0, 0, 0);
         #1;
         chk($sformatf("bp%0d.stall", k), {31'h0, stallreq_for_bus}, 32'h1);
         @(posedge clk); #1;
         chk($sformatf("bp%0d.bus_req", k),  {31'h0, bus_req}, 32'h1);
         chk($sformatf("bp%0d.bus_addr", k), bus_addr, 32'hBFC00010);
         chk($sformatf("bp%0d.inst_ok", k),  {31'h0, inst_ok}, 32'h0);
      end
      drive(1, 32'hBFC00010, 0, 0, 0, 0, 1, 1, 32'h11223344);
      @(posedge clk); #1;
      chk("bp.done.inst_ok",    {31'h0, inst_ok}, 32'h1);
      chk("bp.done.inst_rdata", inst_rdata,       32'h11223344);
      chk("bp.done.bus_req",    {31'h0, bus_req}, 32'h0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("bp.after.inst_ok",   {31'h0, inst_ok}, 32'h0);

      // ---- reset mid-DATA ----
      drive(0, 0, 1, 4'h3, 32'h80000040, 32'h55AA55AA, 0, 0, 0);
      @(posedge clk); #1;
      chk("rst.grant.bus_wen", {28'h0, bus_wen}, 32'h3);
      drive(0, 0, 1, 4'h3, 32'h80000040, 32'h55AA55AA, 1, 0, 0);
      @(posedge clk); #1;
      chk("rst.data.bus_req", {31'h0, bus_req}, 32'h0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2 resetn = 1'b0;
      #1;
      chk_all_zero("rst.async");
      @(posedge clk); #1;
      resetn = 1'b1;
      for (int k = 0; k < 2; k++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF);
         #1;
         chk($sformatf("rst.post%0d.stall", k), {31'h0, stallreq_for_bus}, 32'h0);
         @(posedge clk); #1;
         chk_all_zero($sformatf("rst.post%0d", k));
      end
      // a request is granted at once, so the FSM really is in IDLE
      drive(1, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("rst.idle.bus_req",  {31'h0, bus_req}, 32'h1);
      chk("rst.idle.bus_addr", bus_addr,         32'hBFC00000);
      drive(1, 32'hBFC00000, 0, 0, 0, 0, 1, 1, 32'h0BADF00D);
      @(posedge clk); #1;
      chk("rst.fin.inst_ok",    {31'h0, inst_ok}, 32'h1);
      chk("rst.fin.inst_rdata", inst_rdata,       32'h0BADF00D);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // watchdog so the bench always ends on its own
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
